multi_sevenseg_scan: RTL and testbench
======================================

MULTI_SEVENSEG_SCAN -- requirements
Module: multi_sevenseg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of scanned digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 25000, clk cycles each digit is lit; legal range >= 2.
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period; legal range >= 1.
REQ-004 Parameter BLANK_LEADING, default 1; 1 enables leading-zero suppression.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 digits  input  4*NUM_DIGITS  hex digit values; bits [3:0] are digit 0 (least significant).
REQ-008 dp  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-009 digit_en  input  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
REQ-010 blink  input  NUM_DIGITS  per-digit blink request, active-high.
REQ-011 cathodes  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dp_n  output  1  decimal point segment, active-low, registered.
REQ-013 anodes  output  8  digit select, active-low, one-hot-low or all-high, registered.
REQ-014 frame_tick  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count (REFRESH_DIV-1) is the scan strobe.
REQ-016 Scan index SHALL advance by 1 on each scan strobe, wrapping NUM_DIGITS-1 -> 0.
REQ-017 Index outside 0..NUM_DIGITS-1 SHALL recover to 0 on the next clock.
REQ-018 On each wrap to index 0, digits/dp/digit_en/blink SHALL be captured into shadow registers; mid-frame input changes SHALL not affect the current frame.
REQ-019 frame_tick SHALL be high exactly in the cycle the index becomes 0 via wrap; never asserted by reset.
REQ-020 Blink phase SHALL toggle after every BLINK_FRAMES wraps; frame counter wraps BLINK_FRAMES-1 -> 0.
REQ-021 Digit i is dark when: shadow digit_en[i]=0; or shadow blink[i]=1 and blink phase=1; or leading-blank.
REQ-022 Leading-blank (BLANK_LEADING=1 only): i>0 and shadow digits i..NUM_DIGITS-1 all zero; digit 0 is never leading-blanked.
REQ-023 Dark digit: anodes SHALL be 8'hFF, cathodes 7'h7F, dp_n 1.
REQ-024 Lit digit: anodes bit[index]=0, all others 1; cathodes = hex decode of shadow digit; dp_n = ~shadow dp[index].
REQ-025 Decode (active-low, gfedcba): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
REQ-026 Outputs SHALL reflect the new index one cycle after the scan strobe (registered, latency 1).
REQ-027 anodes bits NUM_DIGITS..7 SHALL be 1 at all times.
REQ-028 NUM_DIGITS=1: index stays 0; frame_tick pulses every REFRESH_DIV cycles.

Reset
REQ-029 rst=1 SHALL set prescaler 0, index 0, frame counter 0, blink phase 0, shadows 0.
REQ-030 During and in the cycle after reset: anodes 8'hFF, cathodes 7'h7F, dp_n 1, frame_tick 0.
REQ-031 Reset asserted mid-frame or mid-blink SHALL abort the scan; first capture occurs at the first wrap after release.
REQ-032 After release, digit 0 lit from the cycle after the first wrap; no display before first capture.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-033 digits=16'h1234, en=4'hF, dp=0, blink=0 -> anodes cycle FE,FD,FB,F7 each 4 clocks; cathodes 19,30,24,79; frame_tick every 16 clocks.
REQ-034 digits=16'h0070, BLANK_LEADING=1 -> digits 3,2 dark (anodes FF, cathodes 7F); digit 1 shows 78; digit 0 shows 40.
REQ-035 digits=16'h0000 -> only digit 0 lit showing 40; digits 1..3 dark.
REQ-036 blink=4'b0001, digits=16'h5555 -> digit 0 lit frames 0-1, dark frames 2-3, repeating; digits 1..3 always 12.
REQ-037 Change digits 16'h1111->16'h2222 while index=2 -> digits 2,3 still show 79 this frame; 24 from next frame.
REQ-038 Assert rst for 1 cycle while index=3, blink phase=1 -> anodes FF next cycle; index/phase 0; first frame_tick 16 clocks after release.

Source files
------------

// File: rtl/multi_sevenseg_scan.sv
// Time-multiplexed hex seven-segment driver for up to eight digits.
// Frame-coherent shadow capture, blink, enable and leading-zero blanking.
module multi_sevenseg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 25000,
  parameter int BLINK_FRAMES  = 64,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [6:0]              cathodes,
  output logic                    dp_n,
  output logic [7:0]              anodes,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    I_LAST = 3'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre;
  logic [2:0]              idx;
  logic [FW-1:0]           fcnt;
  logic                    phase;
  logic                    sh_phase;
  logic                    live;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic strobe;
  logic wrap;

  assign strobe = (pre == P_LAST);
  assign wrap   = strobe && (idx == I_LAST);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      sh_phase   <= 1'b0;
      live       <= 1'b0;
      sh_dig     <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_blink   <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= strobe ? '0 : pre + 1'b1;
      frame_tick <= wrap;
      if (idx > I_LAST)
        idx <= '0;
      else if (strobe)
        idx <= wrap ? 3'd0 : idx + 3'd1;
      if (wrap) begin
        sh_dig   <= digits;
        sh_dp    <= dp;
        sh_en    <= digit_en;
        sh_blink <= blink;
        live     <= 1'b1;
        // phase seen by a frame counts only frames completed before it
        sh_phase <= phase;
        if (fcnt == F_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  logic [31:0] dig_w;
  logic [7:0]  en_w;
  logic [7:0]  dp_w;
  logic [7:0]  bl_w;
  logic [7:0]  lz;
  logic        allz;
  logic [3:0]  cur;
  logic        lead;
  logic        dark;

  assign dig_w = 32'(sh_dig);
  assign en_w  = 8'(sh_en);
  assign dp_w  = 8'(sh_dp);
  assign bl_w  = 8'(sh_blink);
  assign cur   = dig_w[{idx, 2'b00} +: 4];

  // lz[i]: digits i..top are all zero (unused upper digits read as zero)
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      allz  = allz & (dig_w[i*4 +: 4] == 4'h0);
      lz[i] = allz;
    end
  end

  assign lead = (BLANK_LEADING != 0) && (idx != 3'd0) && lz[idx];
  assign dark = !live || (idx > I_LAST) || !en_w[idx]
              || (bl_w[idx] && sh_phase) || lead;

  always_ff @(posedge clk) begin
    if (rst || dark) begin
      anodes   <= 8'hFF;
      cathodes <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      anodes   <= ~(8'd1 << idx);
      cathodes <= seg7(cur);
      dp_n     <= ~dp_w[idx];
    end
  end

endmodule

// File: tb/tb_multi_sevenseg_scan.sv
// Directed scoreboard bench for multi_sevenseg_scan.
// 4 digits, 4 clocks per digit, 2 frames per blink half-period.
module tb_multi_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic [6:0]  cathodes;
  logic        dp_n;
  logic [7:0]  anodes;
  logic        frame_tick;

  always #5 clk = ~clk;

  multi_sevenseg_scan #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .BLINK_FRAMES(2),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits(digits),
    .dp(dp),
    .digit_en(digit_en),
    .blink(blink),
    .cathodes(cathodes),
    .dp_n(dp_n),
    .anodes(anodes),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic       dpn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ca = {c3,c2,c1,c0}; digits not in lit are expected dark
  task automatic push_frame(input logic [3:0] lit, input logic [27:0] ca,
                            input logic [3:0] dpn);
    for (int d = 0; d < 4; d++) begin
      if (lit[d])
        q.push_back('{an: ~(8'd1 << d), ca: ca[d*7 +: 7], dpn: dpn[d]});
      else
        q.push_back('{an: 8'hFF, ca: 7'h7F, dpn: 1'b1});
    end
  endtask

  task automatic run_slot(input string tag, input int d);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_d%0d_queue observed empty expected entry", tag, d);
      e = '{an: 8'hFF, ca: 7'h7F, dpn: 1'b1};
    end else begin
      e = q.pop_front();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_d%0d_c%0d_an", tag, d, k), anodes, e.an);
      chk($sformatf("%s_d%0d_c%0d_ca", tag, d, k), cathodes, e.ca);
      chk($sformatf("%s_d%0d_c%0d_dp", tag, d, k), dp_n, e.dpn);
      chk($sformatf("%s_d%0d_c%0d_ft", tag, d, k), frame_tick,
          (d == 3 && k == 3));
    end
  endtask

  task automatic run_frame(input string tag);
    for (int d = 0; d < 4; d++) run_slot(tag, d);
  endtask

  // wait for the first frame_tick after release; display must stay dark
  task automatic sync(input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (frame_tick) seen = 1;
      else begin
        chk($sformatf("%s_dark_an_%0d", tag, n), anodes, 8'hFF);
        chk($sformatf("%s_dark_ca_%0d", tag, n), cathodes, 7'h7F);
      end
    end
    chk({tag, "_latency"}, n, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    digits   = 16'h1234;
    dp       = 4'h0;
    digit_en = 4'hF;
    blink    = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_an_%0d", i), anodes, 8'hFF);
      chk($sformatf("rst_ca_%0d", i), cathodes, 7'h7F);
      chk($sformatf("rst_dp_%0d", i), dp_n, 1'b1);
      chk($sformatf("rst_ft_%0d", i), frame_tick, 1'b0);
    end
    rst = 1'b0;
    sync("rel");

    digits = 16'h0070;
    push_frame(4'hF, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    run_frame("f0_1234");

    digits = 16'h0000;
    dp     = 4'b0011;
    push_frame(4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
    run_frame("f1_0070");

    digits = 16'h5555;
    dp     = 4'h0;
    blink  = 4'b0001;
    push_frame(4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
    run_frame("f2_0000");

    push_frame(4'b1110, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    run_frame("f3_blink_off");
    push_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    run_frame("f4_blink_on");
    push_frame(4'b1111, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    run_frame("f5_blink_on");

    blink    = 4'h0;
    digit_en = 4'b1011;
    push_frame(4'b1110, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    run_frame("f6_blink_off");

    digits   = 16'h1111;
    digit_en = 4'hF;
    push_frame(4'b1011, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    run_frame("f7_en");

    push_frame(4'hF, {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF);
    run_slot("f8_1111", 0);
    run_slot("f8_1111", 1);
    digits = 16'h2222;
    run_slot("f8_1111", 2);
    run_slot("f8_1111", 3);

    blink = 4'b0001;
    push_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
    run_frame("f9_2222");

    q.push_back('{an: 8'hFF, ca: 7'h7F, dpn: 1'b1});
    q.push_back('{an: 8'hFD, ca: 7'h24, dpn: 1'b1});
    q.push_back('{an: 8'hFB, ca: 7'h24, dpn: 1'b1});
    run_slot("f10", 0);
    run_slot("f10", 1);
    run_slot("f10", 2);

    rst = 1'b1;
    @(negedge clk);
    chk("rst2_an", anodes, 8'hFF);
    chk("rst2_ca", cathodes, 7'h7F);
    chk("rst2_dp", dp_n, 1'b1);
    chk("rst2_ft", frame_tick, 1'b0);
    rst = 1'b0;
    sync("rel2");

    push_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
    run_frame("r0_phase0");
    push_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
    run_frame("r1_phase0");
    push_frame(4'b1110, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
    run_frame("r2_phase1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
